// File: rtl/clk_rst_seq_pkg.sv
// Shared state encoding and sizing helpers for the clk_rst_seq reset sequencer.
// Build option: CLK_RST_SEQ_REQ_FILT_EN enables the ext_rst_req glitch filter.
package clk_rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_ASSERT  = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } seq_state_e;

    localparam int REQ_FILT_LEN = 4;

    // Counter must reach RST_HOLD-1 and STAGE_GAP-1; sized from the larger span.
    function automatic int seq_cnt_w(input int hold, input int nch, input int gap);
        int m;
        m = (hold > nch * gap) ? hold : nch * gap;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/clk_rst_div.sv
// One channel clock-enable divider: shadow divide value, period counter, ce strobe, toggle.
// Build option: none (CLK_RST_SEQ_REQ_FILT_EN only affects the top).
module clk_rst_div
    import clk_rst_seq_pkg::*;
#(
    parameter int               DIV_W    = 8,
    parameter logic [DIV_W-1:0] DIV_INIT = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [DIV_W-1:0] div_i,
    output logic             ce_o,
    output logic             tgl_o
);

    logic [DIV_W-1:0] shadow_q, shadow_d;
    logic [DIV_W-1:0] act_q, act_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;
    logic             tgl_q, tgl_d;

    // The active value only changes at a period boundary, so a reload never cuts a period short.
    always_comb begin
        shadow_d = load_i ? div_i : shadow_q;
        act_d    = act_q;
        cnt_d    = cnt_q;
        ce_d     = 1'b0;
        tgl_d    = tgl_q;
        if (clr_i) begin
            act_d = shadow_q;
            cnt_d = '0;
            tgl_d = 1'b0;
        end else if (cnt_q == act_q) begin
            act_d = shadow_q;
            cnt_d = '0;
            ce_d  = 1'b1;
            tgl_d = ~tgl_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shadow_q <= DIV_INIT;
            act_q    <= DIV_INIT;
            cnt_q    <= '0;
            ce_q     <= 1'b0;
            tgl_q    <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            act_q    <= act_d;
            cnt_q    <= cnt_d;
            ce_q     <= ce_d;
            tgl_q    <= tgl_d;
        end
    end

    assign ce_o  = ce_q;
    assign tgl_o = tgl_q;

endmodule

// File: rtl/clk_rst_seq.sv
// Reset sequencer: holds all channels in reset, releases them in order, then runs per-channel dividers.
// Build option: CLK_RST_SEQ_REQ_FILT_EN requires ext_rst_req high for 4 consecutive cycles.
module clk_rst_seq
    import clk_rst_seq_pkg::*;
#(
    parameter int NUM_CH    = 4,
    parameter int DIV_W     = 8,
    parameter int RST_HOLD  = 500,
    parameter int STAGE_GAP = 16,
    parameter int DIV_INIT  = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ext_rst_req,
    input  logic [NUM_CH*DIV_W-1:0] div_cfg,
    input  logic                    cfg_load,
    output logic [NUM_CH-1:0]       ch_rstn,
    output logic [NUM_CH-1:0]       ch_ce,
    output logic [NUM_CH-1:0]       ch_tgl,
    output logic                    seq_done
);

    localparam int CW = seq_cnt_w(RST_HOLD, NUM_CH, STAGE_GAP);

    seq_state_e        state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUM_CH-1:0] rstn_q, rstn_d;
    logic              done_q, done_d;
    logic              flush;

`ifdef CLK_RST_SEQ_REQ_FILT_EN
    logic [2:0] filt_q;

    always_ff @(posedge clk) begin
        if (rst || !ext_rst_req) begin
            filt_q <= '0;
        end else if (filt_q != 3'(REQ_FILT_LEN - 1)) begin
            filt_q <= filt_q + 3'd1;
        end
    end

    assign flush = ext_rst_req && (filt_q == 3'(REQ_FILT_LEN - 1));
`else
    assign flush = ext_rst_req;
`endif

    // rstn_d fills from bit 0 upward; the last bit setting marks the end of the sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rstn_d  = rstn_q;
        done_d  = done_q;
        if (flush) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
            rstn_d  = '0;
            done_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_ASSERT: begin
                    if (cnt_q == CW'(RST_HOLD - 1)) begin
                        cnt_d   = '0;
                        rstn_d  = NUM_CH'(1);
                        state_d = ST_RELEASE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == CW'(STAGE_GAP - 1)) begin
                        cnt_d  = '0;
                        rstn_d = (rstn_q << 1) | NUM_CH'(1);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: ;
                default: state_d = ST_ASSERT;
            endcase
            if (state_q != ST_RUN && rstn_d[NUM_CH-1]) begin
                state_d = ST_RUN;
                done_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_rst_div #(
            .DIV_W    (DIV_W),
            .DIV_INIT (DIV_W'(DIV_INIT))
        ) u_div (
            .clk_i  (clk),
            .rst_i  (rst),
            .clr_i  (flush | ~rstn_q[i]),
            .load_i (cfg_load),
            .div_i  (div_cfg[i*DIV_W +: DIV_W]),
            .ce_o   (ch_ce[i]),
            .tgl_o  (ch_tgl[i])
        );
    end

    assign ch_rstn  = rstn_q;
    assign seq_done = done_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
// Directed bench for clk_rst_seq: power-up sequence, dividers, reload, ext request, single channel.
// Build option: CLK_RST_SEQ_REQ_FILT_EN adds the request filter scenario.
module tb_clk_rst_seq;

`ifdef CLK_RST_SEQ_REQ_FILT_EN
    localparam int RL = 4;
`else
    localparam int RL = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, req, load;
    logic [31:0] cfg;
    logic [3:0]  rstn, ce, tgl;
    logic        done;

    logic        rst1, req1, load1;
    logic [7:0]  cfg1;
    logic [0:0]  rstn1, ce1, tgl1;
    logic        done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    clk_rst_seq #(
        .NUM_CH(4), .DIV_W(8), .RST_HOLD(500), .STAGE_GAP(16), .DIV_INIT(0)
    ) dut (
        .clk(clk), .rst(rst), .ext_rst_req(req), .div_cfg(cfg),
        .cfg_load(load), .ch_rstn(rstn), .ch_ce(ce), .ch_tgl(tgl),
        .seq_done(done)
    );

    clk_rst_seq #(
        .NUM_CH(1), .DIV_W(8), .RST_HOLD(1), .STAGE_GAP(16), .DIV_INIT(0)
    ) dut1 (
        .clk(clk), .rst(rst1), .ext_rst_req(req1), .div_cfg(cfg1),
        .cfg_load(load1), .ch_rstn(rstn1), .ch_ce(ce1), .ch_tgl(tgl1),
        .seq_done(done1)
    );

    task automatic test_reset();
        int t_rel[4];
        int t_done;
        int bad_ce;
        rst = 1; req = 0; load = 0; cfg = '0;
        rst1 = 1; req1 = 0; load1 = 0; cfg1 = '0;
        repeat (10) @(negedge clk);
        checks++;
        if (rstn !== 4'h0 || ce !== 4'h0 || tgl !== 4'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs rstn=%b ce=%b tgl=%b done=%b want all 0",
                     rstn, ce, tgl, done);
        end
        rst = 0;
        foreach (t_rel[i]) t_rel[i] = -1;
        t_done = -1;
        bad_ce = 0;
        for (int k = 1; k <= 560; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rstn[i] === 1'b1 && t_rel[i] < 0) t_rel[i] = k;
                if (rstn[i] !== 1'b1 && ce[i] !== 1'b0) bad_ce++;
            end
            if (done === 1'b1 && t_done < 0) t_done = k;
            if (k == 501) begin
                checks++;
                if (ce[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL pwr_ce0_first got=%b want=1", ce[0]);
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t_rel[i] != 500 + 16 * i) begin
                errors++;
                $display("FAIL pwr_rel_ch%0d got=%0d want=%0d", i, t_rel[i], 500 + 16 * i);
            end
        end
        checks++;
        if (t_done != 548) begin
            errors++;
            $display("FAIL pwr_seq_done got=%0d want=548", t_done);
        end
        checks++;
        if (bad_ce != 0) begin
            errors++;
            $display("FAIL pwr_ce_in_reset got=%0d want=0", bad_ce);
        end
    endtask

    task automatic test_ext_pulse();
        req = 1;
        for (int k = 1; k <= RL; k++) begin
            @(negedge clk);
            if (k < RL) begin
                checks++;
                if (done !== 1'b1) begin
                    errors++;
                    $display("FAIL ext_early k=%0d done=%b want=1", k, done);
                end
            end
        end
        checks++;
        if (rstn !== 4'h0 || ce !== 4'h0 || tgl !== 4'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL ext_pulse rstn=%b ce=%b tgl=%b done=%b want all 0",
                     rstn, ce, tgl, done);
        end
        req = 0;
    endtask

    task automatic test_hold_div();
        int t_rel[4];
        int first[4];
        int second[4];
        logic [3:0] tg1, tg2;
        int divs[4];
        int bad_tgl;
        divs = '{0, 1, 4, 255};
        req = 1;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 5) begin
                load = 1;
                cfg = {8'd255, 8'd4, 8'd1, 8'd0};
            end else begin
                load = 0;
            end
        end
        checks++;
        if (rstn !== 4'h0 || done !== 1'b0) begin
            errors++;
            $display("FAIL hold_in_reset rstn=%b done=%b want 0", rstn, done);
        end
        req = 0;
        foreach (t_rel[i]) begin
            t_rel[i] = -1; first[i] = -1; second[i] = -1;
        end
        tg1 = '0; tg2 = '0;
        for (int k = 1; k <= 1070; k++) begin
            @(negedge clk);
            for (int i = 0; i < 4; i++) begin
                if (rstn[i] === 1'b1 && t_rel[i] < 0) t_rel[i] = k;
                if (ce[i] === 1'b1) begin
                    if (first[i] < 0) begin
                        first[i] = k; tg1[i] = tgl[i];
                    end else if (second[i] < 0) begin
                        second[i] = k; tg2[i] = tgl[i];
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (t_rel[i] != 500 + 16 * i) begin
                errors++;
                $display("FAIL hold_rel_ch%0d got=%0d want=%0d", i, t_rel[i], 500 + 16 * i);
            end
            checks++;
            if (first[i] != 500 + 16 * i + divs[i] + 1) begin
                errors++;
                $display("FAIL div_first_ch%0d got=%0d want=%0d",
                         i, first[i], 500 + 16 * i + divs[i] + 1);
            end
            checks++;
            if (second[i] - first[i] != divs[i] + 1) begin
                errors++;
                $display("FAIL div_period_ch%0d got=%0d want=%0d",
                         i, second[i] - first[i], divs[i] + 1);
            end
        end
        bad_tgl = 0;
        if (tg1 !== 4'hF) bad_tgl++;
        if (tg2 !== 4'h0) bad_tgl++;
        checks++;
        if (bad_tgl != 0) begin
            errors++;
            $display("FAIL div_tgl first=%b second=%b want 1111 0000", tg1, tg2);
        end
    endtask

    task automatic test_reload();
        int t[3];
        int n;
        for (int k = 0; k < 20 && ce[2] !== 1'b1; k++) @(negedge clk);
        checks++;
        if (ce[2] !== 1'b1) begin
            errors++;
            $display("FAIL reload_sync got=%b want=1 within 20 cycles", ce[2]);
            return;
        end
        load = 1;
        cfg[23:16] = 8'd9;
        @(negedge clk);
        load = 0;
        n = 0;
        t = '{-1, -1, -1};
        for (int j = 2; j <= 40; j++) begin
            @(negedge clk);
            if (ce[2] === 1'b1 && n < 3) begin
                t[n] = j;
                n++;
            end
        end
        checks++;
        if (t[0] != 5) begin
            errors++;
            $display("FAIL reload_old_period got=%0d want=5", t[0]);
        end
        checks++;
        if (t[1] - t[0] != 10) begin
            errors++;
            $display("FAIL reload_new_period1 got=%0d want=10", t[1] - t[0]);
        end
        checks++;
        if (t[2] - t[1] != 10) begin
            errors++;
            $display("FAIL reload_new_period2 got=%0d want=10", t[2] - t[1]);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        checks++;
        if (rstn1 !== 1'b0 || done1 !== 1'b0 || ce1 !== 1'b0) begin
            errors++;
            $display("FAIL single_reset rstn=%b done=%b ce=%b want 0", rstn1, done1, ce1);
        end
        rst1 = 0;
        @(negedge clk);
        checks++;
        if (rstn1 !== 1'b1 || done1 !== 1'b1 || ce1 !== 1'b0) begin
            errors++;
            $display("FAIL single_release rstn=%b done=%b ce=%b want 1 1 0",
                     rstn1, done1, ce1);
        end
        @(negedge clk);
        checks++;
        if (ce1 !== 1'b1 || tgl1 !== 1'b1) begin
            errors++;
            $display("FAIL single_ce1 ce=%b tgl=%b want 1 1", ce1, tgl1);
        end
        @(negedge clk);
        checks++;
        if (ce1 !== 1'b1 || tgl1 !== 1'b0) begin
            errors++;
            $display("FAIL single_ce2 ce=%b tgl=%b want 1 0", ce1, tgl1);
        end
    endtask

`ifdef CLK_RST_SEQ_REQ_FILT_EN
    task automatic test_filter();
        int lost;
        lost = 0;
        req = 1;
        repeat (3) @(negedge clk);
        req = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done !== 1'b1 || rstn !== 4'hF) lost++;
        end
        checks++;
        if (lost != 0) begin
            errors++;
            $display("FAIL filt_short_pulse got=%0d drops want=0", lost);
        end
        req = 1;
        repeat (3) @(negedge clk);
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL filt_early done=%b want=1", done);
        end
        @(negedge clk);
        req = 0;
        checks++;
        if (done !== 1'b0 || rstn !== 4'h0 || ce !== 4'h0) begin
            errors++;
            $display("FAIL filt_long_pulse done=%b rstn=%b ce=%b want 0", done, rstn, ce);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_ext_pulse();
        test_hold_div();
        test_reload();
        test_single();
`ifdef CLK_RST_SEQ_REQ_FILT_EN
        test_filter();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
